multimsgtx: RTL and testbench
=============================

MULTIMSGTX -- requirements
Module: multimsgtx

Interface
REQ-001 Parameter CLOCK_RATE_HZ, default 12_000_000, system clock frequency.
REQ-002 Parameter BAUD_RATE, default 9_600; the UART divider SHALL be CLOCK_RATE_HZ/BAUD_RATE, truncated to 24 bits.
REQ-003 Parameter LGMEM, default 11, log2 of message memory depth in bytes.
REQ-004 Parameter LGNMSG, default 2, log2 of message slot count; slot size is 2^(LGMEM-LGNMSG) bytes.
REQ-005 Parameter PERIOD_CLKS, default CLOCK_RATE_HZ, periodic restart interval in clocks.
REQ-006 Parameter FIRST_DELAY, default 22, clocks from reset to the first periodic tick.
REQ-007 Parameter INIT_FILE, default "memfile.hex", hex image loaded into message memory.
REQ-008 i_clk  in  1  sole clock; all logic on rising edge.
REQ-009 i_reset  in  1  synchronous, active-high reset.
REQ-010 i_mode  in  1  0 = periodic restart, 1 = triggered.
REQ-011 i_trigger  in  1  single-cycle start request, honoured only when i_mode=1.
REQ-012 i_msg_sel  in  LGNMSG  slot to transmit, sampled only at start.
REQ-013 o_uart_tx  out  1  8N1 serial output, idle high.
REQ-014 o_busy  out  1  high while a message is in progress or the UART is busy.
REQ-015 o_done  out  1  one-cycle pulse when a message completes.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, SEND, DONE.
REQ-017 Period counter SHALL count down to 0, assert a one-cycle tick at 0, then reload PERIOD_CLKS-1, independent of i_mode.
REQ-018 In IDLE, start SHALL occur on (i_mode=0 and tick) or (i_mode=1 and i_trigger); on start, base <= i_msg_sel, offset <= 0, state -> FETCH.
REQ-019 Start requests outside IDLE SHALL be dropped, not queued.
REQ-020 FETCH SHALL present address {base,offset}; the registered read data SHALL be valid the following cycle.
REQ-021 Cycle after FETCH: byte 0x00 SHALL go to DONE without strobing; any other byte SHALL assert tx_stb with that byte and enter SEND.
REQ-022 In SEND, tx_stb and tx_data SHALL hold until accepted (tx_stb && !tx_busy); tx_data SHALL NOT change while tx_stb is high.
REQ-023 On acceptance: if offset = slot size - 1, then DONE, else offset+1 and FETCH; tx_stb SHALL drop in the same cycle.
REQ-024 DONE SHALL assert o_done for exactly one cycle, then return to IDLE.
REQ-025 An empty message (first byte 0x00) SHALL still pulse o_done, with no UART strobe.
REQ-026 A message with no 0x00 SHALL send exactly slot-size bytes, and offset SHALL never wrap into the next slot.
REQ-027 o_busy SHALL be (state != IDLE) or tx_busy.
REQ-028 Offset width SHALL be LGMEM-LGNMSG bits; the address is the concatenation, with no adder carry into base.

Reset
REQ-029 Reset SHALL force: state IDLE, tx_stb 0, offset 0, base 0, o_done 0, period counter FIRST_DELAY.
REQ-030 Reset mid-message SHALL drop tx_stb next cycle; a character already accepted by the UART completes; o_busy follows tx_busy until idle.
REQ-031 Memory contents SHALL NOT be altered by reset.
REQ-032 Initial values SHALL equal reset values.

Structure
REQ-033 State encoding and default parameter constants SHALL live in shared package msgtx_pkg.
REQ-034 The serial port SHALL be the existing txuart sub-module (divider, stb, data, tx, busy); the block SHALL contain no other sub-module.
REQ-035 Under FORMAL, txuart SHALL be replaced by a cutout: busy is free, except it is forced high the cycle after acceptance and for at least 3 cycles.

Verification
REQ-036 mode=0, slot 0 = "Hi\0": after FIRST_DELAY+1 clocks, 'H' then 'i' on the wire, o_done one pulse, no third strobe.
REQ-037 mode=1, i_msg_sel=2, trigger pulse; slot 2 first byte 0x00 -> o_done 2 cycles later, tx_stb never high.
REQ-038 LGMEM=6, LGNMSG=2, slot 1 all 0x41 -> exactly 16 bytes sent from addresses 16..31, then o_done.
REQ-039 Trigger and i_msg_sel changes mid-message -> ignored; the message completes from the originally latched slot.
REQ-040 Reset asserted during the 3rd byte of SEND -> tx_stb low next cycle, state IDLE; the next periodic start occurs FIRST_DELAY+1 clocks after reset release.
REQ-041 Formal: tx_data stable while tx_stb && tx_busy; a chosen (anyconst) address's byte equals tx_data when that address is accepted; cover o_done.

Source files
------------

// File: rtl/msgtx_pkg.sv
// Shared definitions for the multi-message UART transmitter.
// Holds the sequencer state encoding, the default parameter constants and
// the baud-divider helper used to size the UART divider.
package msgtx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned DEF_CLOCK_RATE_HZ = 12_000_000;
  localparam int unsigned DEF_BAUD_RATE     = 9_600;
  localparam int unsigned DEF_LGMEM         = 11;
  localparam int unsigned DEF_LGNMSG        = 2;
  localparam int unsigned DEF_FIRST_DELAY   = 22;
  localparam int unsigned DIV_W             = 24;

  // Clocks per serial bit, truncated to the divider width.
  function automatic logic [DIV_W-1:0] uart_divider(input int unsigned clk_hz,
                                                    input int unsigned baud);
    return DIV_W'(clk_hz / baud);
  endfunction

endpackage

// File: rtl/multimsgtx_if.sv
// Control/status bundle of the multi-message transmitter.
//   i_mode    : 0 = periodic restart, 1 = triggered
//   i_trigger : single-cycle start request (triggered mode only)
//   i_msg_sel : message slot, sampled at start
//   o_uart_tx : 8N1 serial line, idle high
//   o_busy    : message in progress or UART busy
//   o_done    : one-cycle pulse at message completion
interface multimsgtx_if #(
  parameter int unsigned LGNMSG = msgtx_pkg::DEF_LGNMSG
);
  logic              i_mode;
  logic              i_trigger;
  logic [LGNMSG-1:0] i_msg_sel;
  logic              o_uart_tx;
  logic              o_busy;
  logic              o_done;

  modport master (
    output i_mode, i_trigger, i_msg_sel,
    input  o_uart_tx, o_busy, o_done
  );

  modport slave (
    input  i_mode, i_trigger, i_msg_sel,
    output o_uart_tx, o_busy, o_done
  );
endinterface

// File: rtl/txuart.sv
// 8N1 serial transmitter.
//   clk     : clock
//   divider : clocks per bit
//   stb     : byte request, accepted when stb && !busy
//   data    : byte to send, must be stable while stb is high
//   tx      : serial line, idle high
//   busy    : frame in progress
// There is deliberately no reset: a character already accepted always
// finishes on the wire. The all-zero register state is the idle state.
module txuart
  import msgtx_pkg::*;
(
  input  logic             clk,
  input  logic [DIV_W-1:0] divider,
  input  logic             stb,
  input  logic [7:0]       data,
  output logic             tx,
  output logic             busy
);
`ifdef FORMAL
  // Abstract cutout: busy is free except for a forced window after acceptance.
  (* anyseq *) logic free_busy;
  logic [1:0] hold;

  assign busy = free_busy || (hold != 2'd0);
  assign tx   = 1'b1;

  always_ff @(posedge clk) begin
    if (stb && !busy) hold <= 2'd3;
    else if (hold != 2'd0) hold <= hold - 2'd1;
  end
`else
  localparam int unsigned FRAME_BITS = 10;

  logic [DIV_W-1:0]      baud_cnt;
  logic [3:0]            bits_left;
  logic [FRAME_BITS-1:0] frame_n;   // inverted frame, LSB is on the wire

  assign busy = (bits_left != 4'd0);
  assign tx   = ~frame_n[0];

  // Load {stop, data, start} inverted, then shift one bit per divider period.
  always_ff @(posedge clk) begin
    if (!busy) begin
      if (stb) begin
        frame_n   <= ~{1'b1, data, 1'b0};
        bits_left <= 4'(FRAME_BITS);
        baud_cnt  <= divider - DIV_W'(1);
      end
    end else if (baud_cnt != '0) begin
      baud_cnt <= baud_cnt - DIV_W'(1);
    end else begin
      frame_n   <= frame_n >> 1;
      bits_left <= bits_left - 4'd1;
      baud_cnt  <= divider - DIV_W'(1);
    end
  end
`endif
endmodule

// File: rtl/multimsgtx.sv
// Multi-message UART transmitter: streams a NUL-terminated (or slot-length)
// message from a slotted byte memory, started periodically or on trigger.
//   i_clk   : clock
//   i_reset : synchronous active-high reset
//   bus     : multimsgtx_if.slave (mode/trigger/slot in, tx/busy/done out)
module multimsgtx
  import msgtx_pkg::*;
#(
  parameter int unsigned CLOCK_RATE_HZ = DEF_CLOCK_RATE_HZ,
  parameter int unsigned BAUD_RATE     = DEF_BAUD_RATE,
  parameter int unsigned LGMEM         = DEF_LGMEM,
  parameter int unsigned LGNMSG        = DEF_LGNMSG,
  parameter int unsigned PERIOD_CLKS   = CLOCK_RATE_HZ,
  parameter int unsigned FIRST_DELAY   = DEF_FIRST_DELAY,
  parameter string       INIT_FILE     = "memfile.hex"
) (
  input  logic        i_clk,
  input  logic        i_reset,
  multimsgtx_if.slave bus
);
  localparam int unsigned      LGSLOT      = LGMEM - LGNMSG;
  localparam int unsigned      MEM_DEPTH   = 1 << LGMEM;
  localparam logic [DIV_W-1:0] DIVIDER     = uart_divider(CLOCK_RATE_HZ, BAUD_RATE);
  localparam logic [LGSLOT-1:0] LAST_OFFSET = '1;

  logic [7:0]        mem [MEM_DEPTH];
  logic [7:0]        rd_data;
  logic [LGMEM-1:0]  addr;
  state_t            state;
  logic [LGNMSG-1:0] base;
  logic [LGSLOT-1:0] offset;
  logic              tx_stb;
  logic [7:0]        tx_data;
  logic              tx_busy;
  logic              done;
  logic [31:0]       period_cnt;
  logic              tick;

  // Concatenated address: offset can never carry into the slot number.
  assign addr = {base, offset};
  assign tick = (period_cnt == 32'd0);

  always_ff @(posedge i_clk) rd_data <= mem[addr];

  // Free-running restart timer, independent of mode.
  always_ff @(posedge i_clk) begin
    if (i_reset)   period_cnt <= 32'(FIRST_DELAY);
    else if (tick) period_cnt <= 32'(PERIOD_CLKS - 1);
    else           period_cnt <= period_cnt - 32'd1;
  end

  // Sequencer. In SEND with tx_stb low the fetched byte is being examined;
  // with tx_stb high the byte is waiting for the UART.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state  <= IDLE;
      tx_stb <= 1'b0;
      offset <= '0;
      base   <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if ((!bus.i_mode && tick) || (bus.i_mode && bus.i_trigger)) begin
            base   <= LGNMSG'(bus.i_msg_sel);
            offset <= '0;
            state  <= FETCH;
          end
        end
        FETCH: state <= SEND;
        SEND: begin
          if (!tx_stb) begin
            if (rd_data == 8'h00) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              tx_stb  <= 1'b1;
              tx_data <= rd_data;
            end
          end else if (!tx_busy) begin
            tx_stb <= 1'b0;
            if (offset == LAST_OFFSET) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              offset <= offset + LGSLOT'(1);
              state  <= FETCH;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_busy = (state != IDLE) || tx_busy;
  assign bus.o_done = done;

  txuart u_txuart (
    .clk     (i_clk),
    .divider (DIVIDER),
    .stb     (tx_stb),
    .data    (tx_data),
    .tx      (bus.o_uart_tx),
    .busy    (tx_busy)
  );

`ifdef FORMAL
  (* anyconst *) logic [LGMEM-1:0] f_addr;

  always_ff @(posedge i_clk) begin
    if (!i_reset && !$past(i_reset) && $past(tx_stb && tx_busy) && tx_stb)
      assert (tx_data == $past(tx_data));
    if (tx_stb && !tx_busy && (addr == f_addr))
      assert (tx_data == mem[f_addr]);
    cover (done);
  end
`endif
endmodule

// File: tb/tb_multimsgtx.sv
// Randomized self-checking bench for multimsgtx: a byte-image model predicts
// each message, a serial decoder recovers the bytes from o_uart_tx.
module tb_multimsgtx;
  import msgtx_pkg::*;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned BAUD   = 100_000;
  localparam int unsigned DIV    = CLK_HZ / BAUD;
  localparam int unsigned LGMEM  = 6;
  localparam int unsigned LGNMSG = 2;
  localparam int unsigned SLOT   = 1 << (LGMEM - LGNMSG);
  localparam int unsigned NSLOT  = 1 << LGNMSG;
  localparam int unsigned MEMSZ  = 1 << LGMEM;
  localparam int unsigned PERIOD = 3000;
  localparam int unsigned FIRST  = 22;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multimsgtx_if #(.LGNMSG(LGNMSG)) bus ();

  multimsgtx #(
    .CLOCK_RATE_HZ (CLK_HZ),
    .BAUD_RATE     (BAUD),
    .LGMEM         (LGMEM),
    .LGNMSG        (LGNMSG),
    .PERIOD_CLKS   (PERIOD),
    .FIRST_DELAY   (FIRST),
    .INIT_FILE     ("")
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference image and expected-message model.
  logic [7:0] img [MEMSZ];
  logic [7:0] exp_q [$];

  task automatic put_byte(input int a, input logic [7:0] v);
    img[a]     = v;
    dut.mem[a] = v;
  endtask

  task automatic fill_exp(input int slot);
    exp_q.delete();
    for (int o = 0; o < int'(SLOT); o++) begin
      if (img[slot*SLOT + o] == 8'h00) break;
      exp_q.push_back(img[slot*SLOT + o]);
    end
  endtask

  // Serial decoder: samples each bit in its middle.
  logic [7:0] rx_q [$];
  logic [7:0] rx_byte;
  int frame_starts = 0;
  int stop_errs = 0;

  always begin
    @(negedge bus.o_uart_tx);
    frame_starts++;
    repeat (DIV/2) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      repeat (DIV) @(posedge clk);
      #1;
      rx_byte[i] = bus.o_uart_tx;
    end
    repeat (DIV) @(posedge clk);
    #1;
    if (bus.o_uart_tx !== 1'b1) stop_errs++;
    rx_q.push_back(rx_byte);
  end

  // Done pulse counter and width monitor.
  int done_count = 0;
  int done_wide = 0;
  logic done_prev = 1'b0;

  always @(posedge clk) begin
    #1;
    if (bus.o_done === 1'b1) begin
      done_count++;
      if (done_prev) done_wide++;
    end
    done_prev = bus.o_done;
  end

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.o_busy !== 1'b0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_idle_reached"}, 32'(n < 4000), 32'd1);
    repeat (20) @(negedge clk);
  endtask

  task automatic compare_rx(input string tag, input int rx0);
    check_eq({tag, "_len"}, 32'(rx_q.size() - rx0), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && rx0 + i < rx_q.size(); i++)
      check_eq($sformatf("%s_b%0d", tag, i), 32'(rx_q[rx0 + i]), 32'(exp_q[i]));
  endtask

  task automatic run_msg(input int slot, input bit glitch, input string tag);
    int rx0, d0, n;
    fill_exp(slot);
    rx0 = rx_q.size();
    d0  = done_count;
    @(negedge clk);
    bus.i_msg_sel = LGNMSG'(slot);
    bus.i_trigger = 1'b1;
    @(negedge clk);
    bus.i_trigger = 1'b0;
    n = 0;
    while (done_count == d0 && n < 5000) begin
      if (glitch) begin
        bus.i_msg_sel = LGNMSG'($urandom);
        bus.i_trigger = 1'($urandom);
      end
      @(negedge clk);
      n++;
    end
    bus.i_trigger = 1'b0;
    check_eq({tag, "_done_seen"}, 32'(done_count != d0), 32'd1);
    wait_idle(tag);
    compare_rx(tag, rx0);
    check_eq({tag, "_done_cnt"}, 32'(done_count - d0), 32'd1);
  endtask

  int n, lat, rx0, d0, f0;

  initial begin
    bus.i_mode    = 1'b0;
    bus.i_trigger = 1'b0;
    bus.i_msg_sel = '0;

    // Image: "Hi\0", all 'A', empty, and a full random slot without NUL.
    for (int a = 0; a < int'(MEMSZ); a++) put_byte(a, 8'($urandom_range(1, 255)));
    put_byte(0, 8'h48);
    put_byte(1, 8'h69);
    put_byte(2, 8'h00);
    for (int o = 0; o < int'(SLOT); o++) put_byte(int'(SLOT) + o, 8'h41);
    put_byte(2*SLOT, 8'h00);

    repeat (3) @(negedge clk);
    check_eq("reset_busy", 32'(bus.o_busy), 32'd0);
    check_eq("reset_done", 32'(bus.o_done), 32'd0);
    check_eq("reset_tx_idle", 32'(bus.o_uart_tx), 32'd1);

    // Periodic start of slot 0 after the first delay.
    rx0 = rx_q.size();
    d0  = done_count;
    rst = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (bus.o_busy !== 1'b1 && n < 100);
    check_eq("first_tick_latency", 32'(n), 32'(FIRST + 1));
    @(negedge clk);
    bus.i_mode = 1'b1;
    n = 0;
    while (done_count == d0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    fill_exp(0);
    wait_idle("hi");
    compare_rx("hi", rx0);
    check_eq("hi_done_cnt", 32'(done_count - d0), 32'd1);

    // Empty slot: done two edges after the trigger edge, no frame.
    f0 = frame_starts;
    d0 = done_count;
    @(negedge clk);
    bus.i_msg_sel = LGNMSG'(2);
    bus.i_trigger = 1'b1;
    @(negedge clk);
    bus.i_trigger = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (bus.o_done === 1'b1 && lat == 0) lat = k;
    end
    check_eq("empty_done_latency", 32'(lat), 32'd2);
    check_eq("empty_no_frame", 32'(frame_starts - f0), 32'd0);
    check_eq("empty_done_cnt", 32'(done_count - d0), 32'd1);
    wait_idle("empty");

    run_msg(1, 1'b0, "full_A");
    run_msg(3, 1'b0, "full_rand");
    run_msg(3, 1'b1, "glitch");

    for (int it = 0; it < 6; it++) begin
      int s, zpos;
      s    = $urandom_range(0, NSLOT - 1);
      zpos = $urandom_range(0, 2*SLOT - 1);
      for (int o = 0; o < int'(SLOT); o++)
        put_byte(s*SLOT + o, (o == zpos) ? 8'h00 : 8'($urandom_range(1, 255)));
      run_msg(s, 1'($urandom), $sformatf("rnd%0d", it));
    end

    // Reset during the third byte; accepted character still completes.
    for (int o = 0; o < int'(SLOT); o++) put_byte(int'(SLOT) + o, 8'h41);
    f0  = frame_starts;
    rx0 = rx_q.size();
    d0  = done_count;
    @(negedge clk);
    bus.i_msg_sel = LGNMSG'(1);
    bus.i_mode    = 1'b0;
    n = 0;
    while (frame_starts < f0 + 3 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check_eq("midrst_third_frame", 32'(frame_starts - f0), 32'd3);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_stb_low", 32'(dut.tx_stb), 32'd0);
    check_eq("midrst_state_idle", 32'(dut.state), 32'(IDLE));
    check_eq("midrst_busy_uart", 32'(bus.o_busy), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (dut.state == IDLE && n < 100);
    check_eq("midrst_restart_latency", 32'(n), 32'(FIRST + 1));
    @(negedge clk);
    bus.i_mode = 1'b1;
    n = 0;
    while (done_count == d0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    wait_idle("midrst");
    for (int i = 0; i < 3 + int'(SLOT); i++) exp_q.push_back(8'h41);
    exp_q = exp_q[exp_q.size() - (3 + SLOT) : exp_q.size() - 1];
    compare_rx("midrst", rx0);
    check_eq("midrst_done_cnt", 32'(done_count - d0), 32'd1);

    check_eq("done_width", 32'(done_wide), 32'd0);
    check_eq("stop_bits", 32'(stop_errs), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
